// File: rtl/ddr2_port_arbiter_pkg.sv
// Shared DDR2 cache-port definitions: default widths, rw encoding and
// arbiter state encoding.
package ddr2_mem_defs;

   localparam int unsigned DEF_ADDR_W = 28;
   localparam int unsigned DEF_DATA_W = 256;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

endpackage

// File: rtl/ddr2_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins outright, and a tie goes to
// the requester that was not served last.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_valid,
   input  logic       i_update,
   input  logic       i_served,
   output logic       o_any,
   output logic       o_pick
);

   // Last-served resets to 1, so requester 0 wins the first tie.
   logic r_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (i_update) begin
         r_last <= i_served;
      end
   end

   always_comb begin
      o_any  = |i_valid;
      o_pick = 1'b0;
      case (i_valid)
         2'b10:   o_pick = 1'b1;
         2'b11:   o_pick = ~r_last;
         default: o_pick = 1'b0;
      endcase
   end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Shares one DDR2 cache-side memory port between the Icache (0) and the
// Dcache (1). It latches the winning command and routes completion back.
module ddr2_port_arbiter
   import ddr2_mem_defs::*;
#(
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_rw,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        req_ready,
   output logic [DATA_W-1:0] req_rdata,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              grant_id,
   output logic              busy,
   output logic              error
);

   localparam int unsigned     TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]   TO_MAX  = TW'(TIMEOUT_CYCLES);

   logic [1:0]        r_state;
   logic              r_mem_valid;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_grant;
   logic              r_error;
   logic [TW-1:0]     r_tcnt;

   logic w_any;
   logic w_pick;
   logic w_done;

   assign w_done = (r_state == ST_ISSUE) && mem_ready;

   rr_arbiter2 u_rr (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (req_valid),
      .i_update (w_done),
      .i_served (r_grant),
      .o_any    (w_any),
      .o_pick   (w_pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mem_valid <= 1'b0;
         r_mem_rw    <= RW_READ;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_grant     <= 1'b0;
         r_error     <= 1'b0;
         r_tcnt      <= '0;
      end else begin
         if (mem_ready && (r_state != ST_ISSUE)) begin
            r_error <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state     <= ST_ISSUE;
                  r_mem_valid <= 1'b1;
                  r_grant     <= w_pick;
                  r_mem_rw    <= w_pick ? req_rw[1] : req_rw[0];
                  r_mem_addr  <= w_pick ? req_addr1 : req_addr0;
                  r_mem_wdata <= w_pick ? req_wdata1 : req_wdata0;
                  r_tcnt      <= '0;
               end
            end
            ST_ISSUE: begin
               if (mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_state     <= ST_TURN;
               end else if (r_tcnt != TO_MAX) begin
                  // Counter saturates; the command keeps waiting after timeout.
                  r_tcnt <= r_tcnt + TW'(1);
                  if (r_tcnt == TO_LAST) begin
                     r_error <= 1'b1;
                  end
               end
            end
            ST_TURN: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = w_done ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
   assign req_rdata = mem_rdata;
   assign mem_valid = r_mem_valid;
   assign mem_rw    = r_mem_rw;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign grant_id  = r_grant;
   assign busy      = (r_state != ST_IDLE);
   assign error     = r_error;

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Bench for ddr2_port_arbiter: a vector table of single-requester commands plus
// hand-written sequences, with a queue scoreboard checking memory and ready sides.
module tb_ddr2_port_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid;
   logic [1:0]    req_rw;
   logic [27:0]   req_addr0, req_addr1;
   logic [255:0]  req_wdata0, req_wdata1;
   logic [1:0]    req_ready;
   logic [255:0]  req_rdata;
   logic          mem_valid, mem_rw;
   logic [27:0]   mem_addr;
   logic [255:0]  mem_wdata, mem_rdata;
   logic          mem_ready;
   logic          grant_id, busy, error;

   ddr2_port_arbiter #(.ADDR_W(28), .DATA_W(256), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .req_ready(req_ready), .req_rdata(req_rdata),
      .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant_id(grant_id), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         grant;
      logic         rw;
      logic [27:0]  addr;
      logic [255:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [1:0]   rdy;
      logic [255:0] rdata;
   } rdy_t;

   typedef struct {
      logic         id;
      logic         rw;
      logic [27:0]  addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
      int unsigned  delay;
      logic         exp_grant;
      logic [1:0]   exp_ready;
   } vec_t;

   cmd_t q_cmd[$];
   rdy_t q_rdy[$];
   cmd_t cur;
   logic cur_ok = 1'b0;
   logic prev_mv = 1'b0;
   logic mon_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event occurred with nothing expected", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: command side on mem_valid rising, completion side on req_ready.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_valid && !prev_mv) begin
            if (q_cmd.size() == 0) begin
               fail_now("cmd_unexpected");
               cur_ok = 1'b0;
            end else begin
               cur = q_cmd.pop_front();
               cur_ok = 1'b1;
               check("cmd_grant", grant_id, cur.grant);
               check("cmd_rw", mem_rw, cur.rw);
               check("cmd_addr", mem_addr, cur.addr);
               check("cmd_wdata", mem_wdata, cur.wdata);
            end
         end else if (mem_valid && cur_ok) begin
            check("hold_addr", mem_addr, cur.addr);
            check("hold_rw", mem_rw, cur.rw);
         end
         if (req_ready != 2'b00) begin
            if (q_rdy.size() == 0) begin
               fail_now("ready_unexpected");
            end else begin
               rdy_t r;
               r = q_rdy.pop_front();
               check("ready_mask", req_ready, r.rdy);
               check("ready_rdata", req_rdata, r.rdata);
            end
         end
      end
      prev_mv <= mem_valid;
   end

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_mv(input int unsigned exp_cycles, input string name);
      int unsigned n = 0;
      while (!mem_valid && n < 16) begin
         step();
         n++;
      end
      check(name, n, exp_cycles);
   endtask

   task automatic complete(input int unsigned delay, input logic [255:0] rd);
      for (int unsigned k = 0; k < delay; k++) step();
      mem_ready = 1'b1;
      mem_rdata = rd;
      step();
      mem_ready = 1'b0;
      mem_rdata = {8{32'hBADC0DE0}};
   endtask

   vec_t vecs[4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] rd3[3];
      vecs[0] = '{1'b0, 1'b1, 28'h0001010,
                  256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
                  {8{32'hDEADBEEF}}, 3, 1'b0, 2'b01};
      vecs[1] = '{1'b1, 1'b0, 28'h2000000, {8{32'h5A5A5A5A}},
                  {8{32'h0A0A0B0B}}, 1, 1'b1, 2'b10};
      vecs[2] = '{1'b1, 1'b1, 28'hFFFFFFF, {256{1'b1}},
                  256'h0, 0, 1'b1, 2'b10};
      vecs[3] = '{1'b0, 1'b0, 28'h0000000, 256'h0,
                  {8{32'hFFFF0000}}, 5, 1'b0, 2'b01};

      rst = 1'b1; req_valid = '0; req_rw = '0; req_addr0 = '0; req_addr1 = '0;
      req_wdata0 = '0; req_wdata1 = '0; mem_rdata = '0; mem_ready = 1'b0;
      do_reset();
      mon_en = 1'b1;

      check("rst_mem_valid", mem_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_grant", grant_id, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_mem_rw", mem_rw, 1'b0);
      check("rst_mem_addr", mem_addr, 28'h0);
      check("rst_mem_wdata", mem_wdata, 256'h0);
      check("rst_req_ready", req_ready, 2'b00);

      // Single-requester commands from the table.
      for (int i = 0; i < 4; i++) begin
         q_cmd.push_back('{vecs[i].exp_grant, vecs[i].rw, vecs[i].addr, vecs[i].wdata});
         q_rdy.push_back('{vecs[i].exp_ready, vecs[i].rdata});
         req_valid = vecs[i].id ? 2'b10 : 2'b01;
         req_rw[vecs[i].id] = vecs[i].rw;
         if (vecs[i].id) begin
            req_addr1 = vecs[i].addr; req_wdata1 = vecs[i].wdata;
         end else begin
            req_addr0 = vecs[i].addr; req_wdata0 = vecs[i].wdata;
         end
         wait_mv(1, "vec_latency");
         complete(vecs[i].delay, vecs[i].rdata);
         req_valid = '0;
         check("vec_turn_mv", mem_valid, 1'b0);
         check("vec_turn_busy", busy, 1'b1);
         step();
         check("vec_idle_busy", busy, 1'b0);
      end

      // Both held from reset: 0, 1, 0 with the next command at M+3.
      do_reset();
      rd3[0] = {8{32'h00C0FFEE}}; rd3[1] = {8{32'h12345678}}; rd3[2] = {8{32'h9ABCDEF0}};
      req_addr0 = 28'h0000100; req_wdata0 = {8{32'hAAAA0000}};
      req_addr1 = 28'h0000200; req_wdata1 = {8{32'hBBBB1111}};
      req_rw = 2'b00;
      q_cmd.push_back('{1'b0, 1'b0, 28'h0000100, {8{32'hAAAA0000}}});
      q_cmd.push_back('{1'b1, 1'b0, 28'h0000200, {8{32'hBBBB1111}}});
      q_cmd.push_back('{1'b0, 1'b0, 28'h0000100, {8{32'hAAAA0000}}});
      q_rdy.push_back('{2'b01, rd3[0]});
      q_rdy.push_back('{2'b10, rd3[1]});
      q_rdy.push_back('{2'b01, rd3[2]});
      req_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wait_mv((i == 0) ? 1 : 2, "rr_gap");
         complete(1, rd3[i]);
         if (i == 2) req_valid = '0;
      end
      step();

      // Requester inputs change while the command is outstanding.
      q_cmd.push_back('{1'b0, 1'b0, 28'h0444440, {8{32'h44444444}}});
      q_rdy.push_back('{2'b01, {8{32'h0F0F0F0F}}});
      req_valid = 2'b01; req_rw = 2'b00; req_addr0 = 28'h0444440; req_wdata0 = {8{32'h44444444}};
      wait_mv(1, "hold_latency");
      req_addr0 = 28'h0FFFFF0; req_rw = 2'b01; req_wdata0 = {8{32'h99999999}};
      for (int i = 0; i < 3; i++) step();
      check("hold_mem_addr", mem_addr, 28'h0444440);
      check("hold_mem_rw", mem_rw, 1'b0);
      check("hold_mem_wdata", mem_wdata, {8{32'h44444444}});
      complete(0, {8{32'h0F0F0F0F}});
      req_valid = '0;
      step();

      // Timeout after 8 ISSUE cycles; late completion still works.
      q_cmd.push_back('{1'b0, 1'b1, 28'h0ABCDE0, {8{32'h77777777}}});
      q_rdy.push_back('{2'b01, {8{32'h31415926}}});
      req_valid = 2'b01; req_rw = 2'b01; req_addr0 = 28'h0ABCDE0; req_wdata0 = {8{32'h77777777}};
      wait_mv(1, "to_latency");
      for (int i = 0; i < 7; i++) step();
      check("to_error_7", error, 1'b0);
      step();
      check("to_error_8", error, 1'b1);
      check("to_mem_valid", mem_valid, 1'b1);
      for (int i = 0; i < 3; i++) step();
      check("to_mem_valid_late", mem_valid, 1'b1);
      complete(0, {8{32'h31415926}});
      req_valid = '0;
      step();
      check("to_error_sticky", error, 1'b1);

      // Spurious mem_ready in IDLE.
      do_reset();
      check("spur_error_pre", error, 1'b0);
      mem_ready = 1'b1;
      #1;
      check("spur_req_ready", req_ready, 2'b00);
      step();
      mem_ready = 1'b0;
      check("spur_error", error, 1'b1);

      // Reset mid-ISSUE drops the command and restores requester-0 priority.
      do_reset();
      q_cmd.push_back('{1'b0, 1'b0, 28'h0000040, {8{32'h01010101}}});
      q_rdy.push_back('{2'b01, {8{32'h02020202}}});
      req_valid = 2'b01; req_rw = 2'b00; req_addr0 = 28'h0000040; req_wdata0 = {8{32'h01010101}};
      wait_mv(1, "rst_pre_latency");
      complete(0, {8{32'h02020202}});
      req_valid = '0;
      step();
      q_cmd.push_back('{1'b1, 1'b0, 28'h0000080, {8{32'h03030303}}});
      req_valid = 2'b10; req_rw = 2'b00; req_addr1 = 28'h0000080; req_wdata1 = {8{32'h03030303}};
      wait_mv(1, "rst_drop_latency");
      step();
      rst = 1'b1;
      req_valid = '0;
      step();
      rst = 1'b0;
      check("midrst_mem_valid", mem_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_error", error, 1'b0);
      check("midrst_grant", grant_id, 1'b0);
      q_cmd.push_back('{1'b0, 1'b0, 28'h0000040, {8{32'h01010101}}});
      q_rdy.push_back('{2'b01, {8{32'h04040404}}});
      req_valid = 2'b11;
      wait_mv(1, "midrst_latency");
      complete(1, {8{32'h04040404}});
      req_valid = '0;
      step();
      step();

      check("cmd_queue_empty", q_cmd.size(), 0);
      check("ready_queue_empty", q_rdy.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
